clip_recorder_ctrl: RTL and testbench

Parametrised record/playback controller for the audio clip recorder. It manages NUM_CLIPS fixed-size clip regions in one shared sample memory and sequences record and play passes on sample ticks. Each pass can run to a full clip or be stopped early, and the recorded length of every clip is tracked. It sits between the button/clip-select front end, the deserializer (record path), the serializer (play path) and the sample memory.

---
 rtl/clip_recorder_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_clip_recorder_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clip_recorder_ctrl.sv
// clip_recorder_ctrl
// Record/playback sequencer for the audio clip recorder. The shared sample
// memory is split into NUM_CLIPS fixed regions of CLIP_WORDS samples each.
// A pass (record or play) runs against one region, advancing on sampleTick,
// and ends either at the region/clip boundary or on a stop press. The number
// of samples captured by the last completed record pass is kept per clip and
// bounds later playback of that clip.

module clip_recorder_ctrl #(
  parameter int NUM_CLIPS  = 2,
  parameter int CLIP_WORDS = 65536,
  parameter int ADDR_W     = 17,
  parameter int CLIP_W     = $clog2(NUM_CLIPS),
  parameter int LEN_W      = $clog2(CLIP_WORDS + 1)
) (
  input  logic                 clock,
  input  logic                 ResetB,
  input  logic [CLIP_W-1:0]    clipSel,
  input  logic                 playButton,
  input  logic                 recordButton,
  input  logic                 stopButton,
  input  logic                 loopMode,
  input  logic                 sampleTick,
  output logic                 memEn,
  output logic                 memWen,
  output logic [ADDR_W-1:0]    memAddr,
  output logic                 enableDes,
  output logic                 enableS,
  output logic [CLIP_W-1:0]    activeClip,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CLIPS-1:0] clipValid
);

  // Pass sequencing states. FINISH is a single-cycle state that carries the
  // done pulse and guarantees one idle cycle between passes.
  typedef enum logic [1:0] {
    ST_STANDBY = 2'd0,
    ST_RECORD  = 2'd1,
    ST_PLAY    = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

  // Offset of the final slot of a region, and the length of a full region.
  localparam logic [LEN_W-1:0] LAST_SLOT = LEN_W'(CLIP_WORDS - 1);
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(CLIP_WORDS);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    offset_q, offset_d;
  logic [CLIP_W-1:0]   active_clip_q, active_clip_d;
  logic [LEN_W-1:0]    len_q [NUM_CLIPS];
  logic [LEN_W-1:0]    len_d [NUM_CLIPS];

  logic                play_prev_q, rec_prev_q, stop_prev_q;
  logic                play_edge, rec_edge, stop_edge;

  logic [LEN_W-1:0]    cur_len;
  logic [LEN_W-1:0]    offset_inc;
  logic                len_wr_en;
  logic [LEN_W-1:0]    len_wr_val;
  logic [ADDR_W-1:0]   pass_addr;

  // Rising-edge detection on the three buttons; levels held high act once.
  assign play_edge = playButton   & ~play_prev_q;
  assign rec_edge  = recordButton & ~rec_prev_q;
  assign stop_edge = stopButton   & ~stop_prev_q;

  assign offset_inc = offset_q + LEN_W'(1);

  // Region base plus offset; the offset never exceeds CLIP_WORDS-1, so the
  // sum stays inside the selected region.
  assign pass_addr = (ADDR_W'(active_clip_q) * ADDR_W'(CLIP_WORDS))
                   + ADDR_W'(offset_q);

  // Recorded length of the clip latched for the current pass. Compared by
  // index so a clipSel value beyond NUM_CLIPS-1 reads as an empty clip.
  always_comb begin
    cur_len = '0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (active_clip_q == CLIP_W'(i)) cur_len = len_q[i];
    end
  end

  // Next-state logic for the pass FSM, the sample offset and clip lengths.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    offset_d      = offset_q;
    active_clip_d = active_clip_q;
    len_wr_en     = 1'b0;
    len_wr_val    = '0;

    case (state_q)
      ST_STANDBY: begin
        // Play wins over record; stop has nothing to stop here.
        if (play_edge) begin
          active_clip_d = clipSel;
          offset_d      = '0;
          state_d       = ST_PLAY;
        end else if (rec_edge) begin
          active_clip_d = clipSel;
          offset_d      = '0;
          state_d       = ST_RECORD;
        end
      end

      ST_RECORD: begin
        if (stop_edge) begin
          // A tick in the same cycle is written, so it is counted.
          len_wr_en  = 1'b1;
          len_wr_val = offset_q + LEN_W'(sampleTick);
          state_d    = ST_FINISH;
        end else if (sampleTick) begin
          if (offset_q == LAST_SLOT) begin
            len_wr_en  = 1'b1;
            len_wr_val = FULL_LEN;
            state_d    = ST_FINISH;
          end else begin
            offset_d = offset_inc;
          end
        end
      end

      ST_PLAY: begin
        if (stop_edge) begin
          state_d = ST_FINISH;
        end else if (cur_len == '0) begin
          // Nothing recorded: end the pass without consuming any tick.
          state_d = ST_FINISH;
        end else if (sampleTick) begin
          if (offset_inc == cur_len) begin
            if (loopMode) offset_d = '0;
            else          state_d  = ST_FINISH;
          end else begin
            offset_d = offset_inc;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_STANDBY;
      end

      default: begin
        state_d = ST_STANDBY;
      end
    endcase

    // Only the clip of the finishing record pass is updated.
    for (int i = 0; i < NUM_CLIPS; i++) begin
      len_d[i] = len_q[i];
      if (len_wr_en && (active_clip_q == CLIP_W'(i))) len_d[i] = len_wr_val;
    end
  end

  // State, offset, active clip and button history registers.
  always_ff @(posedge clock or negedge ResetB) begin
    if (!ResetB) begin
      state_q       <= ST_STANDBY;
      offset_q      <= '0;
      active_clip_q <= '0;
      play_prev_q   <= 1'b0;
      rec_prev_q    <= 1'b0;
      stop_prev_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      offset_q      <= offset_d;
      active_clip_q <= active_clip_d;
      play_prev_q   <= playButton;
      rec_prev_q    <= recordButton;
      stop_prev_q   <= stopButton;
    end
  end

  // Per-clip recorded lengths.
  always_ff @(posedge clock or negedge ResetB) begin
    if (!ResetB) begin
      // NOTE: this small array is cleared on reset on purpose: a reset must leave every clip empty, including one mid-record.
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= len_d[i];
    end
  end

  // Output decode from the registered state. The write strobe follows the
  // sample tick so the sample lands at the offset held during its cycle.
  always_comb begin
    memEn     = 1'b0;
    memWen    = 1'b0;
    memAddr   = '0;
    enableDes = 1'b0;
    enableS   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_RECORD: begin
        memEn     = 1'b1;
        memWen    = sampleTick;
        memAddr   = pass_addr;
        enableDes = 1'b1;
        busy      = 1'b1;
      end
      ST_PLAY: begin
        memEn   = 1'b1;
        memAddr = pass_addr;
        enableS = 1'b1;
        busy    = 1'b1;
      end
      ST_FINISH: begin
        done = 1'b1;
      end
      default: begin
        memEn = 1'b0;
      end
    endcase
  end

  assign activeClip = active_clip_q;

  // A clip is valid once it holds at least one recorded sample.
  always_comb begin
    clipValid = '0;
    for (int i = 0; i < NUM_CLIPS; i++) clipValid[i] = (len_q[i] != '0);
  end

endmodule

// File: tb/tb_clip_recorder_ctrl.sv
// Directed bench for clip_recorder_ctrl with 4 clips of 8 samples.

module tb_clip_recorder_ctrl;

  localparam int NUM_CLIPS  = 4;
  localparam int CLIP_WORDS = 8;
  localparam int ADDR_W     = 5;
  localparam int CLIP_W     = 2;

  logic                 clock = 1'b0;
  logic                 ResetB;
  logic [CLIP_W-1:0]    clipSel;
  logic                 playButton, recordButton, stopButton;
  logic                 loopMode, sampleTick;
  logic                 memEn, memWen, enableDes, enableS, busy, done;
  logic [ADDR_W-1:0]    memAddr;
  logic [CLIP_W-1:0]    activeClip;
  logic [NUM_CLIPS-1:0] clipValid;

  int checks   = 0;
  int failures = 0;

  clip_recorder_ctrl #(
    .NUM_CLIPS (NUM_CLIPS),
    .CLIP_WORDS(CLIP_WORDS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock       (clock),
    .ResetB      (ResetB),
    .clipSel     (clipSel),
    .playButton  (playButton),
    .recordButton(recordButton),
    .stopButton  (stopButton),
    .loopMode    (loopMode),
    .sampleTick  (sampleTick),
    .memEn       (memEn),
    .memWen      (memWen),
    .memAddr     (memAddr),
    .enableDes   (enableDes),
    .enableS     (enableS),
    .activeClip  (activeClip),
    .busy        (busy),
    .done        (done),
    .clipValid   (clipValid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge; returns 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // All outputs at their idle values (STANDBY), with a given clipValid.
  task automatic check_idle(input string tag, input logic [NUM_CLIPS-1:0] valid);
    check({tag, ".busy"},      busy, 0);
    check({tag, ".done"},      done, 0);
    check({tag, ".memEn"},     memEn, 0);
    check({tag, ".memAddr"},   memAddr, 0);
    check({tag, ".clipValid"}, clipValid, valid);
  endtask

  initial begin
    ResetB = 1'b0; clipSel = '0; playButton = 0; recordButton = 0;
    stopButton = 0; loopMode = 0; sampleTick = 0;
    cyc(); cyc();
    check_idle("reset0", 4'b0000);
    check("reset0.activeClip", activeClip, 0);
    ResetB = 1'b1;
    cyc();

    // Reset in the middle of a record pass of clip 2.
    clipSel = 2; recordButton = 1; cyc(); recordButton = 0;
    check("mid.enableDes", enableDes, 1);
    sampleTick = 1; #1;
    check("mid.wen", memWen, 1);
    check("mid.addr", memAddr, 16);
    cyc(); cyc(); sampleTick = 0;
    ResetB = 1'b0; #1;
    check_idle("rst_mid", 4'b0000);
    check("rst_mid.enableDes", enableDes, 0);
    check("rst_mid.activeClip", activeClip, 0);
    check("rst_mid.memWen", memWen, 0);
    cyc(); ResetB = 1'b1; cyc();
    check_idle("post_rst", 4'b0000);

    // Stop edge in STANDBY does nothing.
    stopButton = 1; cyc(); stopButton = 0;
    check_idle("stop_idle", 4'b0000);
    cyc();

    // Full record of clip 2: 8 ticks at 16..23, done after the last.
    clipSel = 2; recordButton = 1; cyc(); recordButton = 0; clipSel = 0;
    check("rec2.busy", busy, 1);
    check("rec2.activeClip", activeClip, 2);
    check("rec2.idle_wen", memWen, 0);
    for (int i = 0; i < 8; i++) begin
      sampleTick = 1; #1;
      check($sformatf("rec2.wen%0d", i), memWen, 1);
      check($sformatf("rec2.addr%0d", i), memAddr, 16 + i);
      check($sformatf("rec2.busy%0d", i), busy, 1);
      cyc();
    end
    sampleTick = 0; #1;
    check("rec2.done", done, 1);
    check("rec2.fin_busy", busy, 0);
    check("rec2.fin_memEn", memEn, 0);
    check("rec2.fin_addr", memAddr, 0);
    check("rec2.valid", clipValid, 4'b0100);
    cyc();
    check_idle("rec2.standby", 4'b0100);

    // Record clip 1, stop coincident with the 3rd tick.
    clipSel = 1; recordButton = 1; cyc(); recordButton = 0;
    for (int i = 0; i < 2; i++) begin
      sampleTick = 1; #1;
      check($sformatf("rec1.addr%0d", i), memAddr, 8 + i);
      cyc();
    end
    sampleTick = 1; stopButton = 1; #1;
    check("rec1.wen_stop", memWen, 1);
    check("rec1.addr_stop", memAddr, 10);
    cyc(); sampleTick = 0; stopButton = 0;
    check("rec1.done", done, 1);
    check("rec1.valid", clipValid, 4'b0110);
    cyc();

    // Play clip 1 once: reads 8,9,10 then done.
    clipSel = 1; playButton = 1; cyc(); playButton = 0;
    check("ply1.enableS", enableS, 1);
    check("ply1.enableDes", enableDes, 0);
    for (int i = 0; i < 3; i++) begin
      sampleTick = 1; #1;
      check($sformatf("ply1.addr%0d", i), memAddr, 8 + i);
      check($sformatf("ply1.wen%0d", i), memWen, 0);
      cyc();
    end
    sampleTick = 0;
    check("ply1.done", done, 1);
    check("ply1.busy", busy, 0);
    cyc();

    // Looped playback of clip 1 for 7 ticks, then stop.
    loopMode = 1; clipSel = 1; playButton = 1; cyc(); playButton = 0;
    for (int i = 0; i < 7; i++) begin
      sampleTick = 1; #1;
      check($sformatf("loop.addr%0d", i), memAddr, 8 + (i % 3));
      check($sformatf("loop.busy%0d", i), busy, 1);
      cyc();
    end
    sampleTick = 0; #1;
    check("loop.still_play", enableS, 1);
    stopButton = 1; cyc(); stopButton = 0; loopMode = 0;
    check("loop.done", done, 1);
    check("loop.busy", busy, 0);
    cyc();
    check_idle("loop.standby", 4'b0110);

    // Empty clip 3: one PLAY cycle with no tick, then FINISH.
    clipSel = 3; playButton = 1; cyc(); playButton = 0;
    check("empty.busy", busy, 1);
    check("empty.addr", memAddr, 24);
    cyc();
    check("empty.done", done, 1);
    check("empty.memEn", memEn, 0);
    check("empty.valid", clipValid, 4'b0110);
    cyc();

    // Play and record together: PLAY wins; held record gives no new pass.
    clipSel = 0; playButton = 1; recordButton = 1; cyc(); playButton = 0;
    check("both.enableS", enableS, 1);
    check("both.enableDes", enableDes, 0);
    check("both.activeClip", activeClip, 0);
    cyc();
    check("both.done", done, 1);
    cyc(); cyc(); cyc();
    check_idle("both.held", 4'b0110);
    check("both.held_des", enableDes, 0);
    recordButton = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
